rand_byte_uart_tx: RTL and testbench
====================================

// Module: rand_byte_uart_tx
// PURPOSE
//  Consumer end of the random-bit shift register. Counts CSReq strobes, captures each completed
//  8-bit randByte, buffers it in a FIFO and transmits it over a UART TX line (8N1, LSB first).
//  Sits between the shift register and the board UART pin that carries the TRNG output to the host.
// PARAMETERS
//  CLKS_PER_BIT  868  clk cycles per UART bit (100 MHz / 115200 baud); legal range 2..65535
//  FIFO_DEPTH    16   byte FIFO entries; power of two, >= 2
// PORTS
//  clk       in   1  system clock; all logic on its rising edge
//  rst       in   1  synchronous, active-high reset
//  CSReq     in   1  one-cycle strobe; the shift register shifts in one bit on it
//  randByte  in   8  parallel output of the shift register
//  txEn      in   1  1 = frames may start; 0 = no new frame starts (capture continues)
//  ovfClr    in   1  clears the sticky overflow flag
//  tx        out  1  UART serial line, idle high
//  busy      out  1  1 while a frame (start..stop) is on the line
//  ovf       out  1  sticky: a completed byte was dropped because the FIFO was full
//  fifoLvl   out  clog2(FIFO_DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset: tx=1, busy=0, ovf=0, fifoLvl=0, bit counter=0, capture-pending=0, FSM=IDLE.
//  Reset mid-frame: tx returns high on the next edge; the frame is aborted; the FIFO is flushed.
//  Capture:
//   - 3-bit counter bitCnt increments on every CSReq and wraps 7->0.
//   - CSReq with bitCnt==7 sets capPend for exactly one cycle.
//   - While capPend=1, randByte (now holding 8 fresh bits) is pushed into the FIFO.
//   - Push happens one cycle after the 8th strobe.
//  FIFO:
//   - Push when full drops the byte and sets ovf.
//   - Push and pop in the same cycle when full: both succeed; level is unchanged; ovf is not set.
//   - Push and pop in the same cycle when empty: pop is not possible, so only the push is taken.
//   - ovf and ovfClr in the same cycle: set wins.
//   - Pointers wrap modulo FIFO_DEPTH.
//  Transmit FSM (IDLE, START, DATA, STOP); bit timer counts 0..CLKS_PER_BIT-1:
//   - IDLE: if txEn and FIFO not empty, pop into shift reg, tx<=0, busy<=1, go to START.
//   - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
//   - DATA: tx=shift[0], held CLKS_PER_BIT cycles per bit; shift right; 8 bits, then go to STOP.
//   - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE with busy<=0.
//   - The next frame may start on the cycle after IDLE is entered, giving 10*CLKS_PER_BIT+1 cycles per byte.
//   - Deasserting txEn mid-frame does not abort the frame; only the next start is blocked.
//  Latency: push at edge N -> tx falls at edge N+1 (FIFO non-empty is seen in IDLE at N+1), given idle and txEn=1.
//  tx, busy and ovf are driven directly from flops (glitch-free pin).
// STRUCTURE
//  Shared package/header rand_tx_pkg: FSM state encodings (IDLE=0, START=1, DATA=2, STOP=3),
//   UART_IDLE_LVL=1'b1, FRAME_DATA_BITS=8.
//  Sub-module uart_tx_serializer:
//   - Contains the FSM, bit timer and shift reg.
//   - Handshake: input valid/data; output ready, high only in IDLE.
//   - Top level holds the capture logic, FIFO and ovf.
// TESTING (CLKS_PER_BIT=4, FIFO_DEPTH=4 in the bench)
//  1 Reset: hold rst 3 cycles -> tx=1, busy=0, ovf=0, fifoLvl=0; no tx edge for 100 cycles.
//  2 Single byte:
//    stimulus: 8 CSReq strobes; randByte=8'hA5 after the 8th; txEn=1.
//    response: tx = 0,1,0,1,0,0,1,0,1,1, each held 4 cycles; busy high for 40 cycles.
//  3 Overflow:
//    stimulus: txEn=0; 5 complete bytes 01..05.
//    response: fifoLvl=4, ovf=1.
//    then: txEn=1 sends 01..04; pulse ovfClr -> ovf=0.
//  4 Full push+pop:
//    stimulus: FIFO full; a push coincides with the IDLE pop.
//    response: fifoLvl stays 4; ovf stays 0.
//  5 txEn drop mid-frame: deassert during DATA bit 3 -> frame completes; no next frame until txEn=1.
//  6 Reset mid-frame: rst during DATA -> tx=1 next cycle; fifoLvl=0; bitCnt restarts (next byte needs 8 strobes).

Source files
------------

// File: rtl/rand_tx_pkg.sv
// Shared definitions for the random-byte UART transmitter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package rand_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    localparam logic UART_IDLE_LVL   = 1'b1;
    localparam int   FRAME_DATA_BITS = 8;

endpackage

// File: rtl/uart_tx_serializer.sv
// 8N1 UART serializer, LSB first: FSM, bit timer and shift register.
// Latency: valid&ready at edge N -> start bit on tx after edge N; 10*CLKS_PER_BIT cycles per frame.
// Backpressure: ready is high only in IDLE; a byte is taken on the edge where valid&ready.
// Ports: clk, rst (sync, active high), valid/data (byte offered), ready (serializer idle),
//        tx (serial line, idle high, registered), busy (start..stop on the line, registered).
module uart_tx_serializer
    import rand_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       valid,
    input  logic [FRAME_DATA_BITS-1:0] data,
    output logic                       ready,
    output logic                       tx,
    output logic                       busy
);

    localparam int             TW       = $clog2(CLKS_PER_BIT);
    localparam logic [TW-1:0]  TMR_LAST = TW'(CLKS_PER_BIT - 1);
    localparam logic [2:0]     BIT_LAST = 3'(FRAME_DATA_BITS - 1);

    tx_state_t                  state, state_n;
    logic [TW-1:0]              timer, timer_n;
    logic [FRAME_DATA_BITS-1:0] shift, shift_n;
    logic [2:0]                 bit_idx, bit_idx_n;
    logic                       tx_n, busy_n;

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            timer   <= '0;
            shift   <= '0;
            bit_idx <= '0;
            tx      <= UART_IDLE_LVL;
            busy    <= 1'b0;
        end else begin
            state   <= state_n;
            timer   <= timer_n;
            shift   <= shift_n;
            bit_idx <= bit_idx_n;
            tx      <= tx_n;
            busy    <= busy_n;
        end
    end

    // tx/busy are next-state values registered above, so the pin never
    // sees combinational decode.
    always_comb begin
        state_n   = state;
        timer_n   = timer;
        shift_n   = shift;
        bit_idx_n = bit_idx;
        tx_n      = tx;
        busy_n    = busy;
        ready     = (state == ST_IDLE);

        unique case (state)
            ST_IDLE: begin
                if (valid) begin
                    shift_n = data;
                    timer_n = '0;
                    tx_n    = 1'b0;
                    busy_n  = 1'b1;
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (timer == TMR_LAST) begin
                    timer_n   = '0;
                    bit_idx_n = '0;
                    tx_n      = shift[0];
                    state_n   = ST_DATA;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_DATA: begin
                if (timer == TMR_LAST) begin
                    timer_n = '0;
                    if (bit_idx == BIT_LAST) begin
                        tx_n    = UART_IDLE_LVL;
                        state_n = ST_STOP;
                    end else begin
                        // shift[1] becomes shift[0] after this edge
                        shift_n   = {1'b0, shift[FRAME_DATA_BITS-1:1]};
                        tx_n      = shift[1];
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            ST_STOP: begin
                if (timer == TMR_LAST) begin
                    timer_n = '0;
                    busy_n  = 1'b0;
                    state_n = ST_IDLE;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: rtl/rand_byte_uart_tx.sv
// Captures every 8th CSReq strobe's randByte into a byte FIFO and sends it out as 8N1 UART.
// Latency: 8th strobe at edge N-1 -> push at edge N -> start bit at edge N+1 (idle, txEn=1).
// Backpressure: none upstream; a byte completed while the FIFO is full is dropped and sets sticky ovf.
// Ports: clk, rst (sync, active high), CSReq (shift strobe), randByte (shift reg contents),
//        txEn (permit new frames), ovfClr (clear ovf), tx (UART line), busy, ovf, fifoLvl.
module rand_byte_uart_tx
    import rand_tx_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_DEPTH   = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       CSReq,
    input  logic [FRAME_DATA_BITS-1:0] randByte,
    input  logic                       txEn,
    input  logic                       ovfClr,
    output logic                       tx,
    output logic                       busy,
    output logic                       ovf,
    output logic [$clog2(FIFO_DEPTH):0] fifoLvl
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int LVL_W = AW + 1;

    // ---------------- capture ----------------
    logic [2:0] bit_cnt;
    logic       cap_pend;

    // cap_pend lands one cycle after the 8th strobe, when randByte holds
    // all eight fresh bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            cap_pend <= 1'b0;
        end else begin
            cap_pend <= CSReq && (bit_cnt == 3'd7);
            if (CSReq) begin
                bit_cnt <= bit_cnt + 3'd1;
            end
        end
    end

    // ---------------- byte FIFO ----------------
    logic [FRAME_DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]              wr_ptr, rd_ptr;
    logic [LVL_W-1:0]           lvl;
    logic                       fifo_empty, fifo_full;
    logic                       ser_valid, ser_ready;
    logic                       pop, push_ok, drop;

    assign fifo_empty = (lvl == '0);
    assign fifo_full  = (lvl == LVL_W'(FIFO_DEPTH));
    assign ser_valid  = txEn && !fifo_empty;
    assign pop        = ser_valid && ser_ready;
    // A pop on the same edge frees the slot, so a push into a full FIFO
    // still succeeds then (the write lands on the slot being read out).
    assign push_ok    = cap_pend && (!fifo_full || pop);
    assign drop       = cap_pend && fifo_full && !pop;
    assign fifoLvl    = lvl;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= randByte;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            lvl    <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop})
                2'b10:   lvl <= lvl + LVL_W'(1);
                2'b01:   lvl <= lvl - LVL_W'(1);
                default: lvl <= lvl;
            endcase
        end
    end

    // Sticky overflow; a drop in the same cycle as ovfClr keeps it set.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf <= 1'b0;
        end else if (drop) begin
            ovf <= 1'b1;
        end else if (ovfClr) begin
            ovf <= 1'b0;
        end
    end

    // ---------------- serializer ----------------
    uart_tx_serializer #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_ser (
        .clk   (clk),
        .rst   (rst),
        .valid (ser_valid),
        .data  (mem[rd_ptr]),
        .ready (ser_ready),
        .tx    (tx),
        .busy  (busy)
    );

endmodule

// File: tb/tb_rand_byte_uart_tx.sv
// Self-checking bench for rand_byte_uart_tx (CLKS_PER_BIT=4, FIFO_DEPTH=4).
// Expected bytes come from a queue model of what the producer sent; the line is
// decoded from its waveform by a frame monitor task.
module tb_rand_byte_uart_tx;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FRAME_CYC = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst, CSReq, txEn, ovfClr;
    logic [7:0] randByte;
    logic       tx, busy, ovf;
    logic [2:0] fifoLvl;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    rand_byte_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .CSReq    (CSReq),
        .randByte (randByte),
        .txEn     (txEn),
        .ovfClr   (ovfClr),
        .tx       (tx),
        .busy     (busy),
        .ovf      (ovf),
        .fifoLvl  (fifoLvl)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // n strobes with random gaps; randByte carries b from the last strobe
    // on and is left holding it (the capture edge is the caller's next tick).
    task automatic send_strobes(input logic [7:0] b, input int n, input int gap_max);
        for (int i = 0; i < n; i++) begin
            CSReq    = 1'b1;
            randByte = (i == n - 1) ? b : 8'($urandom);
            tick();
            CSReq = 1'b0;
            if (i != n - 1) begin
                repeat ($urandom_range(gap_max, 0)) begin
                    randByte = 8'($urandom);
                    tick();
                end
            end
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_strobes(b, 8, 2);
        tick();
        randByte = 8'($urandom);
    endtask

    // Waits (bounded) for a start bit, then samples one whole frame.
    // frame[0] is the start bit, frame[9] the stop bit. ok=0 if any bit
    // slot is not constant for CPB cycles, busy drops inside the frame,
    // or busy/tx are not idle on the cycle after the frame.
    task automatic capture_frame(output logic [9:0] frame, output bit ok,
                                 output bit to, output int t0);
        int n = 0;
        frame = '0;
        ok    = 1'b1;
        to    = 1'b0;
        t0    = 0;
        while (tx !== 1'b0 && n < 300) begin
            tick();
            n++;
        end
        if (tx !== 1'b0) begin
            to = 1'b1;
            return;
        end
        t0 = cyc;
        for (int k = 0; k < FRAME_CYC; k++) begin
            if (k % CPB == 0) frame[k / CPB] = tx;
            else if (tx !== frame[k / CPB]) ok = 1'b0;
            if (busy !== 1'b1) ok = 1'b0;
            tick();
        end
        if (busy !== 1'b0 || tx !== 1'b1) ok = 1'b0;
    endtask

    task automatic test_reset();
        int lows = 0;
        rst = 1'b1; CSReq = 1'b0; txEn = 1'b0; ovfClr = 1'b0; randByte = 8'h00;
        repeat (3) tick();
        checks++; if (tx !== 1'b1)      begin errors++; $display("FAIL reset_tx got %b want 1", tx); end
        checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
        checks++; if (ovf !== 1'b0)     begin errors++; $display("FAIL reset_ovf got %b want 0", ovf); end
        checks++; if (fifoLvl !== 3'd0) begin errors++; $display("FAIL reset_lvl got %0d want 0", fifoLvl); end
        rst  = 1'b0;
        txEn = 1'b1;
        repeat (100) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        checks++; if (lows !== 0) begin errors++; $display("FAIL reset_idle_line low_cycles %0d want 0", lows); end
    endtask

    task automatic test_single_byte();
        logic [9:0] fr; bit ok, to; int t0;
        txEn = 1'b1;
        send_strobes(8'hA5, 8, 1);
        tick();  // push edge
        randByte = 8'h3C;
        checks++; if (fifoLvl !== 3'd1 || tx !== 1'b1) begin errors++; $display("FAIL single_push lvl %0d tx %b want 1 1", fifoLvl, tx); end
        tick();  // start bit edge
        checks++; if (tx !== 1'b0 || busy !== 1'b1 || fifoLvl !== 3'd0) begin
            errors++; $display("FAIL single_latency tx %b busy %b lvl %0d want 0 1 0", tx, busy, fifoLvl); end
        capture_frame(fr, ok, to, t0);
        checks++; if (fr !== {1'b1, 8'hA5, 1'b0}) begin errors++; $display("FAIL single_frame got %b want %b", fr, {1'b1, 8'hA5, 1'b0}); end
        checks++; if ({to, ok} !== 2'b01) begin errors++; $display("FAIL single_timing timeout %b ok %b want 0 1", to, ok); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_q[$];
        fork
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [7:0] b;
                    b = 8'($urandom);
                    exp_q.push_back(b);
                    send_byte(b);
                    repeat ($urandom_range(30, 10)) tick();
                end
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    logic [9:0] fr; bit ok, to; int t0;
                    logic [7:0] eb;
                    capture_frame(fr, ok, to, t0);
                    eb = (exp_q.size() > 0) ? exp_q.pop_front() : 8'hxx;
                    checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, eb, 1'b0}) begin
                        errors++; $display("FAIL stream_byte%0d got %h to %b ok %b want %h", i, fr[8:1], to, ok, eb); end
                end
            end
        join
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL stream_ovf got %b want 0", ovf); end
    endtask

    task automatic test_overflow();
        logic [9:0] fr; bit ok, to; int t0;
        txEn = 1'b0;
        for (int i = 1; i <= 5; i++) send_byte(8'(i));
        checks++; if (fifoLvl !== 3'd4) begin errors++; $display("FAIL ovf_lvl got %0d want 4", fifoLvl); end
        checks++; if (ovf !== 1'b1)     begin errors++; $display("FAIL ovf_set got %b want 1", ovf); end
        txEn = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            capture_frame(fr, ok, to, t0);
            checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, 8'(i), 1'b0}) begin
                errors++; $display("FAIL ovf_drain%0d got %h to %b ok %b want %h", i, fr[8:1], to, ok, 8'(i)); end
        end
        repeat (5) tick();
        checks++; if (fifoLvl !== 3'd0 || ovf !== 1'b1) begin errors++; $display("FAIL ovf_sticky lvl %0d ovf %b want 0 1", fifoLvl, ovf); end
        ovfClr = 1'b1; tick(); ovfClr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", ovf); end
    endtask

    // Leaves the FIFO full (4 bytes, returned in q) with ovf clear and txEn=0.
    task automatic test_ovf_set_wins(output logic [7:0] q[$]);
        txEn = 1'b0;
        q = {};
        for (int i = 0; i < 4; i++) begin
            logic [7:0] b;
            b = 8'($urandom);
            q.push_back(b);
            send_byte(b);
        end
        send_strobes(8'hEE, 8, 1);
        ovfClr = 1'b1;
        tick();  // drop and clear on the same edge
        ovfClr = 1'b0;
        checks++; if (ovf !== 1'b1 || fifoLvl !== 3'd4) begin errors++; $display("FAIL set_wins ovf %b lvl %0d want 1 4", ovf, fifoLvl); end
        ovfClr = 1'b1; tick(); ovfClr = 1'b0;
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL set_wins_clear got %b want 0", ovf); end
    endtask

    task automatic test_full_push_pop(input logic [7:0] q_in[$]);
        logic [7:0] q[$];
        logic [7:0] nb;
        int prev_t0 = 0;
        q  = q_in;
        nb = 8'($urandom);
        send_strobes(nb, 8, 1);
        txEn = 1'b1;
        tick();  // push and pop coincide
        randByte = 8'($urandom);
        q.push_back(nb);
        checks++; if (fifoLvl !== 3'd4 || ovf !== 1'b0 || tx !== 1'b0) begin
            errors++; $display("FAIL full_pushpop lvl %0d ovf %b tx %b want 4 0 0", fifoLvl, ovf, tx); end
        for (int i = 0; i < 5; i++) begin
            logic [9:0] fr; bit ok, to; int t0;
            logic [7:0] eb;
            capture_frame(fr, ok, to, t0);
            eb = q.pop_front();
            checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, eb, 1'b0}) begin
                errors++; $display("FAIL full_drain%0d got %h to %b ok %b want %h", i, fr[8:1], to, ok, eb); end
            if (i > 0) begin
                checks++; if (t0 - prev_t0 !== FRAME_CYC + 1) begin
                    errors++; $display("FAIL frame_spacing got %0d want %0d", t0 - prev_t0, FRAME_CYC + 1); end
            end
            prev_t0 = t0;
        end
    endtask

    task automatic test_txen_drop();
        logic [9:0] fr; bit ok, to; int t0;
        logic [7:0] x, y;
        int active = 0;
        x = 8'($urandom); y = 8'($urandom);
        txEn = 1'b0;
        send_byte(x);
        send_byte(y);
        checks++; if (fifoLvl !== 3'd2) begin errors++; $display("FAIL drop_prefill got %0d want 2", fifoLvl); end
        txEn = 1'b1;
        fork
            capture_frame(fr, ok, to, t0);
            begin
                tick();                    // start bit edge
                repeat (CPB + 3 * CPB + 1) tick();  // into data bit 3
                txEn = 1'b0;
            end
        join
        checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, x, 1'b0}) begin
            errors++; $display("FAIL drop_frame got %h to %b ok %b want %h", fr[8:1], to, ok, x); end
        repeat (60) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) active++;
        end
        checks++; if (active !== 0 || fifoLvl !== 3'd1) begin
            errors++; $display("FAIL drop_hold active %0d lvl %0d want 0 1", active, fifoLvl); end
        txEn = 1'b1;
        capture_frame(fr, ok, to, t0);
        checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, y, 1'b0}) begin
            errors++; $display("FAIL drop_resume got %h to %b ok %b want %h", fr[8:1], to, ok, y); end
    endtask

    task automatic test_reset_mid_frame();
        logic [9:0] fr; bit ok, to; int t0;
        logic [7:0] v;
        int lows = 0;
        txEn = 1'b0;
        send_byte(8'($urandom));
        send_byte(8'($urandom));
        send_strobes(8'($urandom), 3, 1);
        txEn = 1'b1;
        tick();
        repeat (2 * CPB + 2) tick();  // inside data bits
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL midrst_pre busy %b want 1", busy); end
        rst = 1'b1;
        tick();
        checks++; if (tx !== 1'b1 || busy !== 1'b0 || fifoLvl !== 3'd0 || ovf !== 1'b0) begin
            errors++; $display("FAIL midrst tx %b busy %b lvl %0d ovf %b want 1 0 0 0", tx, busy, fifoLvl, ovf); end
        rst = 1'b0;
        v = 8'($urandom);
        send_strobes(v, 7, 1);
        repeat (3) begin
            tick();
            if (tx !== 1'b1) lows++;
        end
        checks++; if (fifoLvl !== 3'd0 || lows !== 0) begin
            errors++; $display("FAIL midrst_7strobes lvl %0d low_cycles %0d want 0 0", fifoLvl, lows); end
        send_strobes(v, 1, 0);
        tick();
        capture_frame(fr, ok, to, t0);
        checks++; if ({to, ok} !== 2'b01 || fr !== {1'b1, v, 1'b0}) begin
            errors++; $display("FAIL midrst_next got %h to %b ok %b want %h", fr[8:1], to, ok, v); end
    endtask

    initial begin
        logic [7:0] fullq[$];
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_ovf_set_wins(fullq);
        test_full_push_pop(fullq);
        test_txen_drop();
        test_reset_mid_frame();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
